// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through an external 4-bit adder.
// The carry is chained between nibbles. Result, carry-out and overflow are held until the next accepted start.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [WIDTH-1:0] a_nx, b_nx, res_nx;
  logic [CW-1:0]    cnt;
  logic             sign_a, sign_b;
  logic             last;

  // Operand registers shift down so that the next nibble is always at [3:0].
  // The sum enters the result register from the top.
  always_comb begin
    a_nx   = a_sh >> 4;
    b_nx   = b_sh >> 4;
    res_nx = (res_sh >> 4) | (WIDTH'(add_s) << (WIDTH - 4));
    last   = (cnt == CW'(NIBBLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      add_a    <= 4'd0;
      add_b    <= 4'd0;
      add_cin  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            cnt     <= '0;
            sign_a  <= a[WIDTH-1];
            sign_b  <= b[WIDTH-1];
            add_a   <= a[3:0];
            add_b   <= b[3:0];
            add_cin <= c_in;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_nx;
          b_sh   <= b_nx;
          res_sh <= res_nx;
          cnt    <= cnt + CW'(1);
          if (last) begin
            add_a    <= 4'd0;
            add_b    <= 4'd0;
            add_cin  <= 1'b0;
            result   <= res_nx;
            c_out    <= add_cout;
            overflow <= (sign_a == sign_b) && (res_nx[WIDTH-1] != sign_a);
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            add_a   <= a_nx[3:0];
            add_b   <= b_nx[3:0];
            add_cin <= add_cout;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
